blend_writer: RTL

Downstream consumer of the sync controller's pixel stream. Each `val` pulse carries a position plus a DVI pixel and the matching CCD pixel. The block merges each pair into one RGB565 pixel using a selectable mode (DVI only, CCD only, alpha blend, or colour key). Results pass through a short queue into the frame-buffer write FIFO, which can apply back-pressure; overflow is counted, never stalls the producer.

---
 rtl/blend_writer_if.sv | 10 +
 rtl/blend_writer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/blend_writer_if.sv
// Frame-buffer write FIFO bus: write strobe and data toward the FIFO,
// full flag back from it.
interface blend_writer_if;
  logic        wrreq;
  logic [35:0] wrdata;
  logic        wrfull;

  modport master (output wrreq, output wrdata, input wrfull);
  modport slave  (input wrreq, input wrdata, output wrfull);
endinterface

// File: rtl/blend_writer.sv
// blend_writer: merges a DVI pixel and a CCD pixel into one RGB565 pixel
// (DVI, CCD, alpha blend or colour key), then queues {x,y,pixel} toward the
// frame-buffer write FIFO. The producer is never stalled; pixels arriving at
// a full queue are dropped and counted.
module blend_writer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned H_LAST = 639,
  parameter int unsigned V_LAST = 479
) (
  input  logic                 clk_25,
  input  logic                 rst_n,
  input  logic                 val,
  input  logic [9:0]           sync_x,
  input  logic [9:0]           sync_y,
  input  logic [4:0]           dvi_r,
  input  logic [5:0]           dvi_g,
  input  logic [4:0]           dvi_b,
  input  logic [4:0]           ccd_r,
  input  logic [5:0]           ccd_g,
  input  logic [4:0]           ccd_b,
  input  logic [1:0]           mode,
  input  logic [4:0]           alpha,
  input  logic [15:0]          key_color,
  blend_writer_if.master       wr,
  output logic                 frame_done,
  output logic [15:0]          drop_cnt,
  output logic                 overflow
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  typedef enum logic [1:0] {
    M_DVI   = 2'd0,
    M_CCD   = 2'd1,
    M_BLEND = 2'd2,
    M_KEY   = 2'd3
  } mode_t;

  // Stage 1 registers
  logic        r_s1_val;
  logic [9:0]  r_s1_x, r_s1_y;
  logic [15:0] r_s1_dvi, r_s1_ccd, r_s1_key;
  mode_t       r_s1_mode;
  logic [4:0]  r_s1_alpha;

  // Stage 2 registers
  logic        r_s2_val;
  logic [35:0] r_s2_data;

  // Queue state
  logic [35:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CNT_W-1:0] r_cnt;

  logic [4:0]  w_alpha_clamp;
  logic [4:0]  w_inv;
  logic [9:0]  w_sum_r, w_sum_b;
  logic [10:0] w_sum_g;
  logic [15:0] w_blend;
  logic [15:0] w_result;
  logic        w_full, w_empty, w_pop, w_push, w_drop, w_last;

  assign w_alpha_clamp = (alpha > 5'd16) ? 5'd16 : alpha;

  // Stage 1: capture position, pixels and the mode controls for this pixel
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_val   <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_dvi   <= '0;
      r_s1_ccd   <= '0;
      r_s1_key   <= '0;
      r_s1_mode  <= M_DVI;
      r_s1_alpha <= '0;
    end else begin
      r_s1_val <= val;
      if (val) begin
        r_s1_x     <= sync_x;
        r_s1_y     <= sync_y;
        r_s1_dvi   <= {dvi_r, dvi_g, dvi_b};
        r_s1_ccd   <= {ccd_r, ccd_g, ccd_b};
        r_s1_key   <= key_color;
        r_s1_mode  <= mode_t'(mode);
        r_s1_alpha <= w_alpha_clamp;
      end
    end
  end

  // Per-channel alpha blend in sixteenths, truncated
  always_comb begin
    w_inv   = 5'd16 - r_s1_alpha;
    w_sum_r = 10'(r_s1_ccd[15:11]) * 10'(r_s1_alpha)
            + 10'(r_s1_dvi[15:11]) * 10'(w_inv);
    w_sum_g = 11'(r_s1_ccd[10:5]) * 11'(r_s1_alpha)
            + 11'(r_s1_dvi[10:5]) * 11'(w_inv);
    w_sum_b = 10'(r_s1_ccd[4:0]) * 10'(r_s1_alpha)
            + 10'(r_s1_dvi[4:0]) * 10'(w_inv);
    w_blend = {5'(w_sum_r >> 4), 6'(w_sum_g >> 4), 5'(w_sum_b >> 4)};
  end

  // Mode select
  always_comb begin
    w_result = r_s1_dvi;
    case (r_s1_mode)
      M_DVI:   w_result = r_s1_dvi;
      M_CCD:   w_result = r_s1_ccd;
      M_BLEND: w_result = w_blend;
      M_KEY:   w_result = (r_s1_ccd == r_s1_key) ? r_s1_dvi : r_s1_ccd;
      default: w_result = r_s1_dvi;
    endcase
  end

  // Stage 2: register the merged pixel with its position
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_val  <= 1'b0;
      r_s2_data <= '0;
    end else begin
      r_s2_val <= r_s1_val;
      if (r_s1_val) r_s2_data <= {r_s1_x, r_s1_y, w_result};
    end
  end

  // Queue control: a pop frees a slot in the same cycle, so a full queue
  // accepts a push whenever it is also popping.
  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_pop   = !w_empty && !wr.wrfull;
  assign w_push  = r_s2_val && (!w_full || w_pop);
  assign w_drop  = r_s2_val && w_full && !w_pop;
  assign w_last  = (wr.wrdata[35:26] == 10'(H_LAST)) &&
                   (wr.wrdata[25:16] == 10'(V_LAST));

  assign wr.wrreq  = w_pop;
  assign wr.wrdata = r_mem[r_rp];

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= r_s2_data;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Drop accounting and end-of-frame pulse
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt   <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (w_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
      frame_done <= w_pop && w_last;
    end
  end

endmodule
